// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls, multi-cycle branch flushes, mem-wait freezes.
// Optional performance counters (stall_cnt/flush_cnt) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic                  IF_ID_use_rs1,
    input  logic                  IF_ID_use_rs2,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic                  ID_EX_MemRead,
    input  logic [1:0]            ID_EX_RegWrite,
    input  logic                  branch_taken,
    input  logic                  mem_wait,
    output logic                  Delay,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  IF_ID_Flush,
    output logic                  pipe_hold
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       lu;

    assign lu = ID_EX_MemRead && (ID_EX_RegWrite != 2'b00) &&
                ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                 (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        Delay       = 1'b0;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        pipe_hold   = 1'b0;
        if (mem_wait) begin
            pipe_hold   = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (state_q == FLUSH) begin
            IF_ID_Flush = 1'b1;
            Delay       = 1'b1;
            fcnt_d      = fcnt_q - 3'd1;
            if (fcnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (branch_taken) begin
            // Any coincident load-use is on the wrong path, so the flush wins.
            IF_ID_Flush = 1'b1;
            Delay       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                fcnt_d  = FLUSH_INIT;
            end
        end else if (lu) begin
            Delay       = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_evt;

    assign stall_evt = mem_wait || ((state_q == RUN) && !branch_taken && lu);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (IF_ID_Flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counter width is only meaningful with the counters present.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a
// remaining-flush-cycles reference model.
module tb_hazard_ctrl;

    localparam int RW   = 4;
    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0;
    logic          IF_ID_use_rs1 = 1'b0, IF_ID_use_rs2 = 1'b0;
    logic          ID_EX_MemRead = 1'b0;
    logic [1:0]    ID_EX_RegWrite = 2'b00;
    logic          branch_taken = 1'b0, mem_wait = 1'b0;
    logic          Delay, PCWrite, IF_ID_Write, IF_ID_Flush, pipe_hold;
`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
        .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .Delay(Delay), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .pipe_hold(pipe_hold)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct packed {
        logic          dly, pcw, ifw, fl, hold;
        logic [CW-1:0] sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_flush_left = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    // Apply one cycle of inputs at posedge+1 and queue the response the model predicts.
    task automatic drive(input logic r, input logic mw, input logic bt, input logic mr,
                         input logic [1:0] rw, input logic [RW-1:0] rd,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2);
        exp_t e;
        logic lu, stall;
        rst_n = r; mem_wait = mw; branch_taken = bt; ID_EX_MemRead = mr;
        ID_EX_RegWrite = rw; ID_EX_rd = rd; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2;
        IF_ID_use_rs1 = u1; IF_ID_use_rs2 = u2;
        lu = mr && (rw != 2'b00) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!r) begin
            m_flush_left = 0; m_sc = 0; m_fc = 0;
        end
        e.sc = CW'(m_sc);
        e.fc = CW'(m_fc);
        e.dly = 1'b0; e.pcw = 1'b1; e.ifw = 1'b1; e.fl = 1'b0; e.hold = 1'b0;
        stall = 1'b0;
        if (mw) begin
            e.hold = 1'b1; e.pcw = 1'b0; e.ifw = 1'b0; stall = 1'b1;
        end else if (m_flush_left > 0) begin
            e.fl = 1'b1; e.dly = 1'b1;
            if (r) m_flush_left--;
        end else if (bt) begin
            e.fl = 1'b1; e.dly = 1'b1;
            if (r) m_flush_left = FC - 1;
        end else if (lu) begin
            e.dly = 1'b1; e.pcw = 1'b0; e.ifw = 1'b0; stall = 1'b1;
        end
        if (r) begin
            if (stall && m_sc < CMAX) m_sc++;
            if (e.fl && m_fc < CMAX) m_fc++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({Delay, PCWrite, IF_ID_Write, IF_ID_Flush, pipe_hold} !=
                {mon_e.dly, mon_e.pcw, mon_e.ifw, mon_e.fl, mon_e.hold}) begin
                failures++;
                $display("FAIL ctrl t=%0t got{Delay,PCWrite,IF_ID_Write,Flush,hold}=%b want=%b",
                         $time, {Delay, PCWrite, IF_ID_Write, IF_ID_Flush, pipe_hold},
                         {mon_e.dly, mon_e.pcw, mon_e.ifw, mon_e.fl, mon_e.hold});
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (stall_cnt != mon_e.sc || flush_cnt != mon_e.fc) begin
                failures++;
                $display("FAIL counters t=%0t got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stall_cnt, flush_cnt, mon_e.sc, mon_e.fc);
            end
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        drive(0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(2);
        // Load-use, then bubble clears it
        drive(1, 0, 0, 1, 2'b01, 4'd3, 4'd0, 4'd3, 0, 1);
        drive(1, 0, 0, 0, 2'b01, 4'd3, 4'd0, 4'd3, 0, 1);
        // No false stall: rs2 unused, then RegWrite=0; register 0 match stalls
        drive(1, 0, 0, 1, 2'b01, 4'd3, 4'd0, 4'd3, 0, 0);
        drive(1, 0, 0, 1, 2'b00, 4'd3, 4'd0, 4'd3, 0, 1);
        drive(1, 0, 0, 1, 2'b10, 4'd0, 4'd0, 4'd5, 1, 0);
        idle(1);
        // Single branch pulse -> three flush cycles
        drive(1, 0, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(4);
        // Branch with load-use, then with mem_wait on top
        drive(1, 0, 1, 1, 2'b01, 4'd3, 4'd3, 4'd0, 1, 0);
        idle(3);
        drive(1, 1, 1, 1, 2'b01, 4'd3, 4'd3, 4'd0, 1, 0);
        idle(3);
        // mem_wait for two cycles while fcnt=2
        drive(1, 0, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(1, 1, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(1, 1, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(1, 0, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(4);
        // Reset in the middle of a flush
        drive(1, 0, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(0, 0, 0, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        drive(0, 0, 1, 0, 2'b00, 4'd0, 4'd0, 4'd0, 0, 0);
        idle(3);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) != 0),
                  1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 6) == 0),
                  1'($urandom),
                  2'($urandom),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  1'($urandom),
                  1'($urandom));
        end
        idle(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller in the ID stage. It produces `Delay` for the downstream control-bubble mux, which zeroes all ID/EX control fields when `Delay` is high. It also produces the PC and IF/ID write enables and the IF/ID flush. It handles load-use stalls, taken-branch flushes of configurable length, and data-memory wait-state freezes. A small FSM with a down-counter sequences the multi-cycle flush.

## Interface
Parameters:
- `REG_ADDR_W`, default 4: width of register address fields.
- `FLUSH_CYCLES`, default 1, legal range 1–7: IF/ID flush cycles per taken branch.
- `CNT_W`, default 16: width of the performance counters (only when `HAZARD_PERF_CNT_EN` is defined).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `IF_ID_rs1`, `IF_ID_rs2` input REG_ADDR_W: source registers of the instruction in ID.
- `IF_ID_use_rs1`, `IF_ID_use_rs2` input 1: the ID instruction actually reads rs1 / rs2.
- `ID_EX_rd` input REG_ADDR_W: destination of the instruction in EX.
- `ID_EX_MemRead` input 1: the instruction in EX is a load.
- `ID_EX_RegWrite` input 2: register-write control of the EX instruction; nonzero means it writes.
- `branch_taken` input 1: EX has resolved a taken branch or jump.
- `mem_wait` input 1: data memory is not ready; the whole pipeline must hold.
- `Delay` output 1: to the control mux; 1 inserts a bubble into ID/EX.
- `PCWrite` output 1: PC register enable.
- `IF_ID_Write` output 1: IF/ID register enable.
- `IF_ID_Flush` output 1: clears IF/ID to NOP at the next edge.
- `pipe_hold` output 1: holds the ID/EX, EX/MEM and MEM/WB registers.
- `stall_cnt`, `flush_cnt` output CNT_W: exist only with `HAZARD_PERF_CNT_EN`.

## Operation
Load-use hazard, `lu`:
- Condition: `ID_EX_MemRead` && (`ID_EX_RegWrite` != 0) && ((`IF_ID_use_rs1` && `IF_ID_rs1` == `ID_EX_rd`) || (`IF_ID_use_rs2` && `IF_ID_rs2` == `ID_EX_rd`)).
- Register 0 is compared like any other register.

States: RUN and FLUSH, plus a 3-bit down-counter `fcnt`.

Output priority is strict: `mem_wait` > FLUSH state > `branch_taken` > `lu` > normal.
- **`mem_wait`=1, any state:**
  - `pipe_hold`=1, `PCWrite`=0, `IF_ID_Write`=0, `IF_ID_Flush`=0, `Delay`=0.
  - State and `fcnt` frozen.
  - `branch_taken` and `lu` are ignored; they re-evaluate once the wait ends, because EX/ID contents are held.
- **FLUSH state:**
  - `IF_ID_Flush`=1, `Delay`=1, `PCWrite`=1, `IF_ID_Write`=1.
  - `fcnt` decrements each cycle.
  - When `fcnt`==1, return to RUN next edge.
- **RUN with `branch_taken`:**
  - `IF_ID_Flush`=1, `Delay`=1, `PCWrite`=1 (loads the target), `IF_ID_Write`=1.
  - If `FLUSH_CYCLES`>1, go to FLUSH with `fcnt`=`FLUSH_CYCLES`-1; otherwise stay in RUN.
  - `lu` in the same cycle is ignored, since the ID instruction is wrong-path.
- **RUN with `lu`:** `Delay`=1, `PCWrite`=0, `IF_ID_Write`=0. One bubble per load; the condition clears next cycle because the bubble has `MemRead`=0.
- **Normal:** `PCWrite`=1, `IF_ID_Write`=1, all other outputs 0.

## Timing
- All enables and `Delay` are combinational from the current state and inputs, and are valid in the same cycle as the hazard.
- Only the state, `fcnt` and the counters are registered.
- Reset (asynchronous, effective immediately):
  - State=RUN, `fcnt`=0, counters=0.
  - Outputs take their RUN values: `PCWrite`=1, `IF_ID_Write`=1, `Delay`=0, `IF_ID_Flush`=0, `pipe_hold`=0 (assuming idle inputs).
- Reset asserted mid-FLUSH aborts the flush immediately.
- A `branch_taken` arriving while in FLUSH is ignored; the flush sequence covers it.

## Configuration
`HAZARD_PERF_CNT_EN`:
- When defined, adds `stall_cnt` and `flush_cnt`. Both are saturating at 2^CNT_W-1 and reset to 0.
- `stall_cnt` increments on every cycle with `lu` stall or `mem_wait` hold.
- `flush_cnt` increments on every cycle with `IF_ID_Flush`=1.
- When undefined, the ports and registers are absent and the remaining behaviour is unchanged.

## Test plan
- **Load-use:** ID_EX_MemRead=1, RegWrite=2'b01, rd=3, IF_ID_rs2=3, use_rs2=1 → Delay=1, PCWrite=0, IF_ID_Write=0 for exactly 1 cycle; next cycle (MemRead=0) Delay=0.
- **No false stall:** same as above but use_rs2=0, or RegWrite=0 → Delay=0, PCWrite=1.
- **Branch flush, FLUSH_CYCLES=3:** one-cycle branch_taken pulse → IF_ID_Flush=1 and Delay=1 for 3 consecutive cycles, then 0; flush_cnt=3 with the macro.
- **Priority:** branch_taken and lu together → flush behaviour, PCWrite=1; add mem_wait=1 → pipe_hold=1, PCWrite=0, Delay=0, state frozen.
- **mem_wait inside FLUSH:** mem_wait high for 2 cycles at fcnt=2 → flush resumes afterwards, total flush cycles still 3.
- **Reset mid-FLUSH:** assert rst_n=0 between clock edges → outputs return to RUN values immediately; counters read 0.
